// File: rtl/cond_negate_pipe_pkg.sv
// Shared mode encoding for the conditional-negation pipeline.
// Imported by the core and the top level.
package cond_negate_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ABS  = 2'b10,
        MODE_NABS = 2'b11
    } mode_e;

    localparam int MODE_W = 2;

endpackage

// File: rtl/cond_negate_core.sv
// Combinational conditional negation with MIN overflow detection.
// Negation is ~(x - 1); a negated MIN is flagged and optionally clamped.
module cond_negate_core
    import cond_negate_pipe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic [WIDTH-1:0]  x,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  y,
    output logic              ovf
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX = ~MIN;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] neg;
    logic             sign;
    logic             do_neg;

    always_comb begin
        neg    = ~(x - ONE);
        sign   = x[WIDTH-1];
        do_neg = 1'b0;
        unique case (mode_e'(mode))
            MODE_PASS: do_neg = 1'b0;
            MODE_NEG:  do_neg = 1'b1;
            MODE_ABS:  do_neg = sign;
            MODE_NABS: do_neg = !sign;
            default:   do_neg = 1'b0;
        endcase
        ovf = do_neg && (x == MIN);
        if (ovf) begin
            y = SATURATE ? MAX : MIN;
        end else begin
            y = do_neg ? neg : x;
        end
    end

endmodule

// File: rtl/cond_negate_pipe.sv
// Two-stage conditional-negation pipeline with valid/ready on both sides
// and a saturating counter of delivered overflowed results.
module cond_negate_pipe
    import cond_negate_pipe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_ovf,
    input  logic              ovf_clr,
    output logic [CNT_W-1:0]  ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_data_q, s1_data_d;
    logic [MODE_W-1:0] s1_mode_q, s1_mode_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic             in_fire;
    logic             s2_load;
    logic             out_fire;
    logic [WIDTH-1:0] core_y;
    logic             core_ovf;

    cond_negate_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .x    (s1_data_q),
        .mode (s1_mode_q),
        .y    (core_y),
        .ovf  (core_ovf)
    );

    // Readiness passes straight through from downstream so both stages
    // can advance on the same edge.
    always_comb begin
        in_ready = !s1_valid_q || !out_valid_q || out_ready;
        in_fire  = in_valid && in_ready;
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        out_fire = out_valid_q && out_ready;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        cnt_d       = cnt_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_data;
            s1_mode_d  = in_mode;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            out_data_d  = core_y;
            out_ovf_d   = core_ovf;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (ovf_clr) begin
            cnt_d = '0;
        end else if (out_fire && out_ovf_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_count = cnt_q;

endmodule
